prog_delay_line: RTL and testbench
==================================

# prog_delay_line

Multi-channel delay line with a runtime-programmable depth. It carries NUM_CH lanes of DATA_WIDTH bits plus a valid tag through a delay of 1..MAX_DELAY enabled clock cycles. Pipeline-wide `enable` stalls it, and `cfg_load` reprograms and flushes it. It is the parametrised successor to the fixed-depth dff-chain delay used to align LSTM gate operands, and replaces per-site fixed delay chains wherever alignment depends on the layer configuration.

## Interface
- DATA_WIDTH, 16, bits per lane
- NUM_CH, 4, number of lanes sharing one delay
- MAX_DELAY, 16, largest supported delay in cycles (≥2)
- DEFAULT_DELAY, MAX_DELAY, active delay after reset
- DELAY_BITS (localparam), $clog2(MAX_DELAY+1)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = advance one step this edge; 0 = hold all data state
- cfg_load  in  1  single-cycle strobe: apply delay_cfg and flush
- delay_cfg  in  DELAY_BITS  requested delay, sampled when cfg_load=1
- in_valid  in  1  data_in lanes carry a real sample
- data_in  in  NUM_CH*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  delayed in_valid
- data_out  out  NUM_CH*DATA_WIDTH  delayed data_in; all zero when out_valid=0
- cur_delay  out  DELAY_BITS  active delay D

## Operation
- Active delay D ∈ [1, MAX_DELAY]. On cfg_load, D ← clamp(delay_cfg): 0→1, >MAX_DELAY→MAX_DELAY.
- Enabled edge: the pair {in_valid, data_in} is captured and appears on outputs exactly D enabled edges later, counting the capture edge as edge 1.
- Disabled edge (enable=0): no capture. Outputs, storage and the pointer hold. Non-enabled edges do not count toward latency.
- Flush on cfg_load: every in-flight valid tag is cleared. Data captured on the same edge as cfg_load (if enable=1) is the first entry under the new D. cfg_load acts regardless of enable.
- out_valid=0 forces data_out to zero. The storage data array needs no reset; only valid tags are reset.
- Lanes are independent in data and share valid, delay and enable.

## Timing
- Reset (has priority over cfg_load and enable): out_valid=0, data_out=0, cur_delay=DEFAULT_DELAY, all valid tags 0, ring pointer 0.
- After reset or flush with enable held high, out_valid stays 0 for D−1 edges. The first captured sample appears after edge D.
- D=1: behaves as a single register stage (output updates on the edge after capture).
- D≥2: ring of D−1 entries plus an output register. The pointer wraps from D−2 to 0 and resets to 0 on cfg_load.
- cur_delay updates on the cfg_load edge.
- Throughput: one sample per enabled edge, with no bubbles at steady state.

## Structure
- Shared header holds the `SD` simulation-delay macro and a `clamp_delay` function reused by other delay blocks.
- Sub-module `delay_ring`: MAX_DELAY−1 × (NUM_CH*DATA_WIDTH+1) storage with write enable, wrap-at-length pointer and a clear-valid input.
- Top level holds the cfg register, D=1 bypass mux, output register and zero-gating.

## Test plan
- Reset then enable=1 with data_in ramp 1,2,3…, in_valid=1, default D=16 → out_valid rises after edge 16 with lanes = 1; data_out=0 before that.
- cfg_load with delay_cfg=4, ramp from 10 → 10 appears after the 4th edge, then 11, 12… every cycle; cur_delay=4.
- D=4, enable low for 3 cycles mid-stream → outputs frozen during the stall, and sequence resumes with no gap or duplicate.
- cfg_load with delay_cfg=2 while 3 valid samples are in flight at D=4 → those samples never appear; the sample captured on the load edge appears 2 edges later.
- delay_cfg=0 → cur_delay=1 with one-edge latency. delay_cfg=31 → cur_delay=16.
- reset asserted mid-stream together with cfg_load → cur_delay=16, out_valid=0 and zero outputs next cycle; no stale sample emerges afterwards.

Source files
------------

// File: rtl/prog_delay_line_pkg.sv
// Shared definitions for the programmable delay blocks: a simulation-delay
// macro and the delay clamp used whenever a new depth is loaded.
`ifndef SD
`define SD
`endif

package prog_delay_line_pkg;

  // Legal depths are 1..max_d; a request of zero means "one stage".
  function automatic int clamp_delay(input int cfg, input int max_d);
    if (cfg <= 0)    return 1;
    if (cfg > max_d) return max_d;
    return cfg;
  endfunction

endpackage

// File: rtl/prog_delay_line_ring.sv
// Circular store of data words with valid tags; the read port shows the entry
// under the pointer, which is the oldest one once the ring has filled.
module delay_ring #(
  parameter int W        = 65,
  parameter int DEPTH    = 15,
  parameter int PTR_BITS = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                we,
  input  logic                clr,
  input  logic [PTR_BITS-1:0] len,
  input  logic                wr_valid,
  input  logic [W-1:0]        wr_data,
  output logic                rd_valid,
  output logic [W-1:0]        rd_data
);
  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d, wr_idx;

  function automatic logic [IDX_BITS-1:0] nxt(input logic [IDX_BITS-1:0] p,
                                              input logic [PTR_BITS-1:0] l);
    return (PTR_BITS'(p) + PTR_BITS'(1) >= l) ? '0 : p + IDX_BITS'(1);
  endfunction

  // A clear restarts the ring, so a write on that edge lands in slot 0.
  always_comb begin
    wr_idx = clr ? '0 : ptr_q;
    vld_d  = clr ? '0 : vld_q;
    ptr_d  = clr ? '0 : ptr_q;
    if (we) begin
      vld_d[wr_idx] = wr_valid;
      ptr_d         = nxt(wr_idx, len);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem_q[wr_idx] <= wr_data;
  end

  assign rd_valid = vld_q[ptr_q];
  assign rd_data  = mem_q[ptr_q];
endmodule

// File: rtl/prog_delay_line.sv
// Multi-lane delay line with a runtime depth of 1..MAX_DELAY enabled cycles;
// D-1 ring slots feed an output register, D=1 bypasses the ring.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CH        = 4,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = MAX_DELAY,
  localparam int DELAY_BITS   = $clog2(MAX_DELAY + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         cfg_load,
  input  logic [DELAY_BITS-1:0]        delay_cfg,
  input  logic                         in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [DELAY_BITS-1:0]        cur_delay
);
  localparam int W = NUM_CH * DATA_WIDTH;

  logic [DELAY_BITS-1:0] d_q, d_d, ring_len;
  logic                  ov_q, ov_d;
  logic [W-1:0]          od_q, od_d;
  logic                  ring_we, rd_valid;
  logic [W-1:0]          rd_data;

  // The depth chosen on a load edge already governs that edge's capture.
  always_comb begin
    d_d = cfg_load ? DELAY_BITS'(clamp_delay(int'(delay_cfg), MAX_DELAY)) : d_q;
  end

  assign ring_len = d_d - DELAY_BITS'(1);
  assign ring_we  = enable && (d_d >= DELAY_BITS'(2));

  delay_ring #(.W(W), .DEPTH(MAX_DELAY - 1), .PTR_BITS(DELAY_BITS)) u_ring (
    .clock    (clock),
    .reset    (reset),
    .we       (ring_we),
    .clr      (cfg_load),
    .len      (ring_len),
    .wr_valid (in_valid),
    .wr_data  (data_in),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  // The output stage is part of the in-flight state, so a load empties it too.
  always_comb begin
    ov_d = ov_q;
    od_d = od_q;
    if (enable) begin
      if (d_d == DELAY_BITS'(1)) begin
        ov_d = in_valid;
        od_d = data_in;
      end else if (cfg_load) begin
        ov_d = 1'b0;
      end else begin
        ov_d = rd_valid;
        od_d = rd_data;
      end
    end else if (cfg_load) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q  <= DELAY_BITS'(DEFAULT_DELAY);
      ov_q <= 1'b0;
    end else begin
      d_q  <= d_d;
      ov_q <= ov_d;
    end
  end

  always_ff @(posedge clock) begin
    od_q <= od_d;
  end

  assign out_valid = ov_q;
  assign data_out  = ov_q ? od_q : '0;
  assign cur_delay = d_q;
endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: a queue of expected samples tagged with
// the enabled-edge count at which each one must reach the outputs.
module tb_prog_delay_line;
  localparam int DW = 16, NC = 4, MD = 16, DB = 5, W = DW * NC;

  logic          clock = 1'b0, reset = 1'b1, enable = 1'b0, cfg_load = 1'b0;
  logic [DB-1:0] delay_cfg = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          out_valid;
  logic [W-1:0]  data_out;
  logic [DB-1:0] cur_delay;

  prog_delay_line #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_DELAY(MD), .DEFAULT_DELAY(MD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_load(cfg_load),
    .delay_cfg(delay_cfg), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .cur_delay(cur_delay)
  );

  always #5 clock = ~clock;

  typedef struct { int due; logic [W-1:0] data; } ent_t;
  ent_t         sb[$];
  int           n_edges = 0, m_d = MD, checks = 0, errors = 0;
  logic         exp_v = 1'b0;
  logic [W-1:0] exp_d = '0;

  function automatic logic [W-1:0] mk(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = 16'(v + i * 256);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  // Drive one edge, advance the reference model, then compare #1 after the edge.
  task automatic step(input logic rst, input logic en, input logic ld,
                      input int cfg, input logic vld, input int val);
    reset = rst; enable = en; cfg_load = ld; delay_cfg = DB'(cfg);
    in_valid = vld; data_in = vld ? mk(val) : mk(val ^ 16'h00ff);
    @(posedge clock);
    if (rst) begin
      sb.delete(); m_d = MD; n_edges = 0; exp_v = 1'b0; exp_d = '0;
    end else begin
      if (ld) begin
        sb.delete();
        m_d = (cfg == 0) ? 1 : (cfg > MD) ? MD : cfg;
        exp_v = 1'b0; exp_d = '0;
      end
      if (en) begin
        n_edges++;
        if (vld) sb.push_back('{due: n_edges + m_d - 1, data: mk(val)});
        if (sb.size() > 0 && sb[0].due == n_edges) begin
          exp_v = 1'b1; exp_d = sb[0].data; void'(sb.pop_front());
        end else begin
          exp_v = 1'b0; exp_d = '0;
        end
      end
    end
    #1;
    check("out_valid", W'(out_valid), W'(exp_v));
    check("data_out",  data_out, exp_d);
    check("cur_delay", W'(cur_delay), W'(m_d));
  endtask

  initial begin
    int v;
    // reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 3, 1, 99);
    // default depth 16, ramp 1..20
    for (int i = 1; i <= 20; i++) step(0, 1, 0, 0, 1, i);
    // load depth 4, ramp from 10
    v = 10;
    step(0, 1, 1, 4, 1, v++);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1, v++);
    // stall three cycles mid-stream
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 500 + i);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, v++);
    // reload to depth 2 while samples are in flight
    step(0, 1, 1, 2, 1, 700);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 701 + i);
    // zero request clamps to 1, with a gap in valid
    step(0, 1, 1, 0, 1, 800);
    step(0, 1, 0, 0, 0, 801);
    for (int i = 2; i < 5; i++) step(0, 1, 0, 0, 1, 800 + i);
    // oversize request clamps to max, load while stalled
    step(0, 0, 1, 31, 1, 900);
    for (int i = 1; i < 20; i++) step(0, 1, 0, 0, 1, 900 + i);
    // reset together with load mid-stream
    step(0, 1, 1, 4, 1, 1000);
    for (int i = 1; i < 4; i++) step(0, 1, 0, 0, 1, 1000 + i);
    step(1, 1, 1, 3, 1, 1100);
    for (int i = 0; i < 18; i++) step(0, 1, 0, 0, (i % 3) != 1, 1200 + i);
    // mixed traffic: random enable/valid with occasional reloads
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 15) == 0)
        step(0, 1'($urandom_range(0, 1)), 1, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 2000 + i);
      else
        step(0, $urandom_range(0, 3) != 0, 0, 0, $urandom_range(0, 3) != 0, 2000 + i);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
